// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes,
// FSM state encoding, default operand width and opcode decode helpers.
package mult_div_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Operand / control / result bundle between the execute stage and the
// multiply/divide unit. The master side issues operations, the slave is the unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MDOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             MTHI;
  logic             MTLO;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, MDOperation, A, B, MTHI, MTLO,
    input  Busy, Done, DivByZero, HI, LO
  );

  modport slave (
    input  Start, MDOperation, A, B, MTHI, MTLO,
    output Busy, Done, DivByZero, HI, LO
  );
endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit. Operands are reduced to magnitudes
// at launch, processed by shift-add multiply or restoring divide, and the
// sign is restored in a single fix-up cycle before HI/LO are written.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  mult_div_if.slave   md
);

  localparam int AW = 2*WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             start_go;

  logic [1:0]       op_q;
  logic             neg_res, neg_rem, dz_q;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] opnd;
  logic [AW-1:0]    acc;

  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             sgn;
  logic [WIDTH-1:0] abs_a, abs_b;

  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_nx;
  logic [WIDTH:0]   trial_top;
  logic [WIDTH-1:0] rem_sub;
  logic             q_bit;
  logic [AW-1:0]    div_nx;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign start_go = (state == S_IDLE) && md.Start;
  assign sgn      = is_signed_op(md.MDOperation);

  md_sign_fix #(.W(WIDTH)) u_abs_a (
    .din (md.A),
    .neg (sgn & md.A[WIDTH-1]),
    .dout(abs_a)
  );

  md_sign_fix #(.W(WIDTH)) u_abs_b (
    .din (md.B),
    .neg (sgn & md.B[WIDTH-1]),
    .dout(abs_b)
  );

  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .din (acc[2*WIDTH-1:0]),
    .neg (neg_res),
    .dout(prod_fix)
  );

  md_sign_fix #(.W(WIDTH)) u_fix_quot (
    .din (acc[WIDTH-1:0]),
    .neg (neg_res),
    .dout(quot_fix)
  );

  md_sign_fix #(.W(WIDTH)) u_fix_rem (
    .din (acc[2*WIDTH-1:WIDTH]),
    .neg (neg_rem),
    .dout(rem_fix)
  );

  // One iteration of each algorithm; the FSM selects which result is kept.
  always_comb begin
    mul_sum   = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
    mul_nx    = {1'b0, mul_sum, acc[WIDTH-1:1]};
    trial_top = acc[2*WIDTH-1:WIDTH-1];
    q_bit     = (trial_top >= {1'b0, opnd});
    rem_sub   = acc[2*WIDTH-2:WIDTH-1] - opnd;
    div_nx    = {1'b0, (q_bit ? rem_sub : acc[2*WIDTH-2:WIDTH-1]),
                 acc[WIDTH-2:0], q_bit};
  end

  // Final HI/LO values chosen at the fix-up cycle, including divide-by-zero.
  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div_op(op_q)) begin
      if (dz_q) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quot_fix;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: launch, 32 iterations, one sign fix-up cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (md.Start) state_nx = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Iteration counter and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      busy_q <= (state_nx != S_IDLE);
      done_q <= (state == S_FIX);
      dbz_q  <= (state == S_FIX) && dz_q;
      if (start_go)            cnt <= '0;
      else if (state == S_RUN) cnt <= cnt + CNT_ONE;
    end
  end

  // Operand capture at launch and accumulator update while running.
  always_ff @(posedge clk) begin
    if (start_go) begin
      op_q    <= md.MDOperation;
      neg_res <= sgn & (md.A[WIDTH-1] ^ md.B[WIDTH-1]);
      neg_rem <= sgn & md.A[WIDTH-1];
      dz_q    <= is_div_op(md.MDOperation) && (md.B == '0);
      a_raw   <= md.A;
      if (is_div_op(md.MDOperation)) begin
        opnd <= abs_b;
        acc  <= {{(WIDTH+1){1'b0}}, abs_a};
      end else begin
        opnd <= abs_a;
        acc  <= {{(WIDTH+1){1'b0}}, abs_b};
      end
    end else if (state == S_RUN) begin
      acc <= is_div_op(op_q) ? div_nx : mul_nx;
    end
  end

  // HI/LO: written by a completed operation or by MTHI/MTLO when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == S_FIX) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if ((state == S_IDLE) && !md.Start) begin
      if (md.MTHI) hi_q <= md.A;
      if (md.MTLO) lo_q <= md.A;
    end
  end

  assign md.Busy      = busy_q;
  assign md.Done      = done_q;
  assign md.DivByZero = dbz_q;
  assign md.HI        = hi_q;
  assign md.LO        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a scoreboard queue of expected
// HI/LO/DivByZero values that a monitor pops on every Done pulse.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic reset;

  mult_div_if #(.WIDTH(32)) mdi ();

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (mdi)
  );

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          ndone  = 0;
  int          nops   = 0;
  logic [31:0] cur_hi = 32'h0;
  logic [31:0] cur_lo = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (mdi.Done) begin
        ndone++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result_hi", mdi.HI, e.hi);
          chk("result_lo", mdi.LO, e.lo);
          chk("result_dbz", {31'b0, mdi.DivByZero}, {31'b0, e.dbz});
        end
      end else if (mdi.DivByZero) begin
        chk("dbz_without_done", 32'd1, 32'd0);
      end
    end
  end

  // Issue one operation from the current negedge; returns at the Done negedge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                        input bit glitch, input bit with_mt);
    int busy_cnt;
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    mdi.MDOperation = op;
    mdi.A = a;
    mdi.B = b;
    mdi.Start = 1'b1;
    mdi.MTHI = with_mt;
    mdi.MTLO = with_mt;
    sb_q.push_back(e);
    nops++;
    @(negedge clk);
    mdi.Start = 1'b0;
    mdi.MTHI = 1'b0;
    mdi.MTLO = 1'b0;
    busy_cnt = 0;
    while (mdi.Busy && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 1 || busy_cnt == 8) begin
        chk("hold_hi", mdi.HI, cur_hi);
        chk("hold_lo", mdi.LO, cur_lo);
      end
      if (busy_cnt == 2) begin
        mdi.A = $urandom;
        mdi.B = $urandom;
      end
      if (glitch && busy_cnt == 5) begin
        mdi.Start = 1'b1;
        mdi.MTHI = 1'b1;
        mdi.A = 32'h0000_1234;
      end
      if (glitch && busy_cnt == 6) begin
        mdi.Start = 1'b0;
        mdi.MTHI = 1'b0;
      end
      @(negedge clk);
    end
    chk("busy_cycles", busy_cnt, 32'd33);
    cur_hi = ehi;
    cur_lo = elo;
  endtask

  // Move-to-HI/LO while idle; checked one cycle later.
  task automatic mt_write(input bit hi_en, input bit lo_en, input logic [31:0] val);
    mdi.A = val;
    mdi.MTHI = hi_en;
    mdi.MTLO = lo_en;
    @(negedge clk);
    mdi.MTHI = 1'b0;
    mdi.MTLO = 1'b0;
    if (hi_en) cur_hi = val;
    if (lo_en) cur_lo = val;
    chk("mt_hi", mdi.HI, cur_hi);
    chk("mt_lo", mdi.LO, cur_lo);
  endtask

  initial begin
    reset = 1'b1;
    mdi.Start = 1'b0;
    mdi.MDOperation = 2'b00;
    mdi.A = 32'h0;
    mdi.B = 32'h0;
    mdi.MTHI = 1'b0;
    mdi.MTLO = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, mdi.Busy}, 32'd0);
    chk("rst_done", {31'b0, mdi.Done}, 32'd0);
    chk("rst_dbz", {31'b0, mdi.DivByZero}, 32'd0);
    chk("rst_hi", mdi.HI, 32'h0);
    chk("rst_lo", mdi.LO, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back operations: each launch lands in the previous Done cycle.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 0);
    run_op(2'b00, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
    run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0, 0);
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 1'b0, 0, 0);
    run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0, 0);
    // Start and MTHI pulsed mid-run are ignored.
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1, 0);

    @(negedge clk);
    mt_write(1, 0, 32'h0000_1234);
    mt_write(0, 1, 32'h0000_ABCD);
    mt_write(1, 1, 32'h0000_0055);

    // Start together with MTHI/MTLO: the move is dropped.
    run_op(2'b01, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0, 0, 1);

    // Asynchronous reset in the middle of a run abandons it.
    @(negedge clk);
    mdi.MDOperation = 2'b01;
    mdi.A = 32'h0000_0003;
    mdi.B = 32'h0000_0005;
    mdi.Start = 1'b1;
    @(negedge clk);
    mdi.Start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, mdi.Busy}, 32'd0);
    chk("arst_done", {31'b0, mdi.Done}, 32'd0);
    chk("arst_hi", mdi.HI, 32'h0);
    chk("arst_lo", mdi.LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cur_hi = 32'h0;
    cur_lo = 32'h0;
    @(negedge clk);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 0);

    repeat (40) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    chk("done_count", ndone, nops);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
